// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: function codes, FSM states, op kinds.
// Division support is enabled by defining MULDIV_DIV_EN.
package muldiv_pkg;

   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTLO  = 6'b010011;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   typedef enum logic [1:0] {MUL_S, MUL_U, DIV_S, DIV_U} op_kind_t;

   function automatic logic is_signed_kind(input op_kind_t kind);
      return (kind == MUL_S) || (kind == DIV_S);
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iteration datapath: shift-add multiply and, with MULDIV_DIV_EN, restoring divide
// on unsigned magnitudes. {o_acc, o_lo} is the product, or remainder/quotient for divide.
module muldiv_iter_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic             i_step,
`ifdef MULDIV_DIV_EN
   input  op_kind_t         i_kind,
   output logic             o_is_div,
   output logic             o_b_zero,
`endif
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_acc,
   output logic [WIDTH-1:0] o_lo
);

   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_nxt_acc;
   logic [WIDTH-1:0] w_nxt_lo;
`ifdef MULDIV_DIV_EN
   logic             r_is_div;
   logic [WIDTH:0]   w_shl;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_sum     = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_b} : '0);
      w_nxt_acc = w_sum[WIDTH:1];
      w_nxt_lo  = {w_sum[0], r_lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
      w_shl  = {r_acc, r_lo[WIDTH-1]};
      w_ge   = (w_shl >= {1'b0, r_b});
      // When w_ge holds the true difference is below r_b, so the low bits are exact.
      w_diff = w_shl[WIDTH-1:0] - r_b;
      if (r_is_div) begin
         w_nxt_acc = w_ge ? w_diff : w_shl[WIDTH-1:0];
         w_nxt_lo  = {r_lo[WIDTH-2:0], w_ge};
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!reset_n) begin
         r_b   <= '0;
         r_acc <= '0;
         r_lo  <= '0;
`ifdef MULDIV_DIV_EN
         r_is_div <= 1'b0;
`endif
      end else if (i_load) begin
         r_b   <= i_b;
         r_acc <= '0;
         r_lo  <= i_a;
`ifdef MULDIV_DIV_EN
         r_is_div <= (i_kind == DIV_S) || (i_kind == DIV_U);
`endif
      end else if (i_step) begin
         r_acc <= w_nxt_acc;
         r_lo  <= w_nxt_lo;
      end
   end

   assign o_acc = r_acc;
   assign o_lo  = r_lo;
`ifdef MULDIV_DIV_EN
   assign o_is_div = r_is_div;
   assign o_b_zero = (r_b == '0);
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO unit controller: FSM, iteration counter, sign fix-up, HI/LO registers, stall and mf* read.
// Defining MULDIV_DIV_EN adds div/divu; otherwise those codes are treated as unrelated.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             issue_valid,
   input  logic [5:0]       function_code,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] mf_data
);

   state_t             r_state;
   state_t             w_next_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_neg;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               w_is_mul;
   logic               w_is_div;
   logic               w_hilo_code;
   logic               w_start;
   logic               w_last;
   logic               w_signed;
   op_kind_t           w_kind;
   logic [WIDTH-1:0]   w_a_op;
   logic [WIDTH-1:0]   w_b_op;
   logic [WIDTH-1:0]   w_core_acc;
   logic [WIDTH-1:0]   w_core_lo;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
`ifdef MULDIV_DIV_EN
   logic               r_sign_a;
   logic               w_core_is_div;
   logic               w_b_zero;
`endif

   always_comb begin
      w_is_mul = (function_code == FN_MULT) || (function_code == FN_MULTU);
`ifdef MULDIV_DIV_EN
      w_is_div = (function_code == FN_DIV) || (function_code == FN_DIVU);
`else
      w_is_div = 1'b0;
`endif
      w_hilo_code = w_is_mul || w_is_div ||
                    (function_code == FN_MFHI) || (function_code == FN_MTHI) ||
                    (function_code == FN_MFLO) || (function_code == FN_MTLO);
      w_kind = MUL_U;
      case (function_code)
         FN_MULT: w_kind = MUL_S;
`ifdef MULDIV_DIV_EN
         FN_DIV:  w_kind = DIV_S;
         FN_DIVU: w_kind = DIV_U;
`endif
         default: w_kind = MUL_U;
      endcase
      w_signed = is_signed_kind(w_kind);
      w_a_op   = (w_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
      w_b_op   = (w_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_start) w_next_state = RUN;
         RUN:     if (w_last)  w_next_state = FIX;
         FIX:     w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      busy    = (r_state != IDLE);
      stall   = busy && issue_valid && w_hilo_code;
      w_start = (r_state == IDLE) && issue_valid && (w_is_mul || w_is_div);
      w_last  = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));
      mf_data = '0;
      if (issue_valid && (function_code == FN_MFHI))      mf_data = r_hi;
      else if (issue_valid && (function_code == FN_MFLO)) mf_data = r_lo;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= '0;
         r_neg  <= 1'b0;
         r_done <= 1'b0;
`ifdef MULDIV_DIV_EN
         r_sign_a <= 1'b0;
`endif
      end else begin
         r_done <= (r_state == FIX);
         if (w_start) begin
            r_cnt <= '0;
            r_neg <= w_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
`ifdef MULDIV_DIV_EN
            r_sign_a <= w_signed && rs_data[WIDTH-1];
`endif
         end else if (r_state == RUN) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_load   (w_start),
      .i_step   (r_state == RUN),
`ifdef MULDIV_DIV_EN
      .i_kind   (w_kind),
      .o_is_div (w_core_is_div),
      .o_b_zero (w_b_zero),
`endif
      .i_a      (w_a_op),
      .i_b      (w_b_op),
      .o_acc    (w_core_acc),
      .o_lo     (w_core_lo)
   );

   assign w_prod     = {w_core_acc, w_core_lo};
   assign w_prod_fix = r_neg ? -w_prod : w_prod;

   // mt* writes are only possible while idle; any HI/LO-class issue is stalled otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (r_state == FIX) begin
`ifdef MULDIV_DIV_EN
         if (w_core_is_div) begin
            r_hi <= r_sign_a ? -w_core_acc : w_core_acc;
            r_lo <= w_b_zero ? '1 : (r_neg ? -w_core_lo : w_core_lo);
         end else begin
            {r_hi, r_lo} <= w_prod_fix;
         end
`else
         {r_hi, r_lo} <= w_prod_fix;
`endif
      end else if ((r_state == IDLE) && issue_valid) begin
         if (function_code == FN_MTHI) r_hi <= rs_data;
         if (function_code == FN_MTLO) r_lo <= rs_data;
      end
   end

   assign hi   = r_hi;
   assign lo   = r_lo;
   assign done = r_done;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer; expected HI/LO pushed at issue, compared on done.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   localparam int         W      = 32;
   localparam logic [5:0] FN_ADD = 6'b100000;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         issue_valid;
   logic [5:0]   function_code;
   logic [W-1:0] rs_data;
   logic [W-1:0] rt_data;
   logic         stall;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic [W-1:0] mf_data;

   typedef struct {
      string        tag;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   exp_t         sb_q[$];
   int           n_checks = 0;
   int           n_errors = 0;
   int           n_done   = 0;
   int           n_ops    = 0;
   logic [W-1:0] last_hi  = '0;
   logic [W-1:0] last_lo  = '0;

   muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .issue_valid   (issue_valid),
      .function_code (function_code),
      .rs_data       (rs_data),
      .rt_data       (rt_data),
      .stall         (stall),
      .busy          (busy),
      .done          (done),
      .hi            (hi),
      .lo            (lo),
      .mf_data       (mf_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         n_done++;
         if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.tag, "_hi"}, hi, e.hi);
            check({e.tag, "_lo"}, lo, e.lo);
            last_hi = e.hi;
            last_lo = e.lo;
         end
      end
   end

   task automatic start_op(input string tag, input logic [5:0] fn,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eh, input logic [W-1:0] el);
      exp_t e;
      e.tag = tag;
      e.hi  = eh;
      e.lo  = el;
      sb_q.push_back(e);
      n_ops++;
      issue_valid   = 1'b1;
      function_code = fn;
      rs_data       = a;
      rt_data       = b;
      #1 check({tag, "_accept_stall"}, stall, 0);
      @(posedge clk);
      #1;
      issue_valid   = 1'b0;
      function_code = FN_ADD;
   endtask

   task automatic wait_done(input string tag);
      int busy_cycles = 0;
      bit seen = 1'b0;
      for (int i = 0; i < 4 * W; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busy_cycles++;
      end
      check({tag, "_done_seen"}, seen, 1);
      check({tag, "_busy_cycles"}, busy_cycles, W + 1);
   endtask

   task automatic run_op(input string tag, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
      @(posedge clk);
      #1;
      start_op(tag, fn, a, b, eh, el);
      wait_done(tag);
      @(negedge clk);
      check({tag, "_done_one_pulse"}, done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      reset_n       = 1'b0;
      issue_valid   = 1'b0;
      function_code = FN_ADD;
      rs_data       = '0;
      rt_data       = '0;
      repeat (2) @(negedge clk);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_stall", stall, 0);
      reset_n = 1'b1;

      run_op("multu_7x6", FN_MULTU, 32'd7, 32'd6, 32'h0, 32'h2A);
      run_op("mult_m3x5", FN_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
      run_op("multu_max", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_op("mult_minmin", FN_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);

      // mfhi held from three cycles after accept until the done cycle
      @(posedge clk);
      #1;
      start_op("mult_stall", FN_MULT, 32'h1234, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFDB98);
      @(posedge clk);
      #1;
      issue_valid   = 1'b1;
      function_code = FN_ADD;
      #1 check("add_busy_no_stall", stall, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      function_code = FN_MFHI;
      seen = 1'b0;
      for (int i = 0; i < 4 * W; i++) begin
         #1;
         if (done) begin
            check("mfhi_done_stall", stall, 0);
            check("mfhi_done_data", mf_data, 32'hFFFFFFFF);
            seen = 1'b1;
            break;
         end
         check("mfhi_busy_stall", stall, 1);
         @(posedge clk);
         #1;
      end
      check("mfhi_done_seen", seen, 1);
      issue_valid   = 1'b0;
      function_code = FN_ADD;
      @(negedge clk);

      // mthi / mtlo / mflo / mfhi while idle
      @(posedge clk);
      #1;
      issue_valid   = 1'b1;
      function_code = FN_MTHI;
      rs_data       = 32'h12345678;
      #1 check("mthi_stall", stall, 0);
      @(posedge clk);
      #1;
      function_code = FN_MTLO;
      rs_data       = 32'hCAFEBABE;
      #1 check("mtlo_stall", stall, 0);
      @(posedge clk);
      #1;
      function_code = FN_MFLO;
      #1;
      check("mflo_data", mf_data, 32'hCAFEBABE);
      check("mflo_stall", stall, 0);
      check("mthi_hi", hi, 32'h12345678);
      function_code = FN_MFHI;
      #1 check("mfhi_data", mf_data, 32'h12345678);
      issue_valid = 1'b0;
      #1 check("mf_idle_zero", mf_data, 0);

      // reset asserted mid-run at counter = 10
      @(posedge clk);
      #1;
      issue_valid   = 1'b1;
      function_code = FN_MULTU;
      rs_data       = 32'hFFFF;
      rt_data       = 32'hFFFF;
      @(posedge clk);
      #1;
      issue_valid   = 1'b0;
      function_code = FN_ADD;
      repeat (10) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst_hi", hi, 0);
      check("midrst_lo", lo, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      last_hi = '0;
      last_lo = '0;
      @(negedge clk);
      reset_n = 1'b1;
      run_op("multu_after_rst", FN_MULTU, 32'd2, 32'd3, 32'h0, 32'd6);

      // back-to-back: second op issued in the done cycle of the first
      @(posedge clk);
      #1;
      start_op("b2b_a", FN_MULTU, 32'd1000, 32'd1000, 32'h0, 32'd1000000);
      wait_done("b2b_a");
      start_op("b2b_b", FN_MULT, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001);
      wait_done("b2b_b");
      @(negedge clk);
      check("b2b_b_done_one_pulse", done, 0);

`ifdef MULDIV_DIV_EN
      run_op("div_m7d2", FN_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divu_9d0", FN_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF);
      run_op("div_100dm7", FN_DIV, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2);
      run_op("div_m5d0", FN_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
      run_op("divu_big", FN_DIVU, 32'hFFFFFFFF, 32'd16, 32'd15, 32'h0FFFFFFF);
`else
      @(posedge clk);
      #1;
      issue_valid   = 1'b1;
      function_code = FN_DIV;
      rs_data       = 32'd77;
      rt_data       = 32'd5;
      #1 check("nodiv_idle_stall", stall, 0);
      @(posedge clk);
      #1;
      issue_valid   = 1'b0;
      function_code = FN_ADD;
      check("nodiv_busy", busy, 0);
      check("nodiv_hi", hi, last_hi);
      check("nodiv_lo", lo, last_lo);
      start_op("mult_nodiv", FN_MULT, 32'd3, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF7);
      issue_valid   = 1'b1;
      function_code = FN_DIVU;
      #1 check("nodiv_busy_stall", stall, 0);
      issue_valid   = 1'b0;
      function_code = FN_ADD;
      wait_done("mult_nodiv");
      @(negedge clk);
      check("mult_nodiv_done_one_pulse", done, 0);
`endif

      repeat (2) @(negedge clk);
      check("done_count", n_done, n_ops);
      check("sb_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle controller and iterative datapath for the HI/LO unit of the single-issue MIPS-subset core. It accepts decoded R-type mult/multu (and optionally div/divu) operations and runs a radix-2 shift-add (or restoring-divide) loop. It owns the HI/LO registers, services mfhi/mflo/mthi/mtlo, and stalls the pipeline while a result is pending.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits; legal range 4..32, even.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  core clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
issue_valid  input  1  decoded R-type instruction present this cycle.
function_code  input  6  instruction bits [5:0].
rs_data  input  WIDTH  source operand A (dividend, or mthi/mtlo data).
rt_data  input  WIDTH  source operand B (divisor).
stall  output  1  combinational; hold the issuing stage this cycle.
busy  output  1  registered; state != IDLE.
done  output  1  registered; one-cycle pulse in the cycle after HI/LO update.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.
mf_data  output  WIDTH  combinational; hi for mfhi, lo for mflo, else 0.

Behaviour:
- Function codes: mfhi 010000, mthi 010001, mflo 010010, mtlo 010011, mult 011000, multu 011001, div 011010, divu 011011. All other codes: ignored, stall=0.
- Reset (async, any state, including mid-run): state=IDLE; hi, lo, busy, done, counter and internal operands = 0.
- States: IDLE, RUN, FIX.
- IDLE + issue_valid + mult/multu: accept at edge t. Latch |A| and |B| for signed, raw values for unsigned. Latch neg = signA^signB (signed only). Clear accumulator and counter. Go to RUN.
- RUN: one iteration per cycle for exactly WIDTH cycles. Shift-add: if multiplier LSB=1, add multiplicand to upper half, then shift the 2*WIDTH product right by 1. The addition is WIDTH+1 bits wide, so the carry is kept. When counter reaches WIDTH-1, go to FIX.
- FIX (1 cycle): write {hi,lo} = neg ? two's-complement of product : product. Go to IDLE. done=1 in the next cycle.
- Latency: accept edge t; hi/lo valid after edge t+WIDTH+1; done high during cycle t+WIDTH+2.
- stall=1 when busy and issue_valid with any HI/LO-class code (mf*, mt*, mult*, div*). No stall for unrelated codes.
- mfhi/mflo when not busy: mf_data is the current register value, stall=0.
- mthi/mtlo when not busy: write rs_data to hi/lo at that edge.
- Issue in the FIX cycle is stalled. Issue in the done cycle is accepted, so back-to-back ops are allowed.
- Signed overflow case (min*min) is exact; the 2*WIDTH product never overflows.

Optional Feature:
- Macro: MULDIV_DIV_EN.
- Defined: div/divu accepted like mult. RUN performs WIDTH restoring-division iterations on magnitudes.
- FIX for div/divu: lo = quotient, negated if signA^signB; hi = remainder, carrying the sign of the dividend.
- Divide by zero (either signedness): hi = rs_data, lo = all ones. This completes on the same latency.
- Not defined: div/divu codes are treated as unrelated. No stall, no HI/LO change, no logic is generated.

Decomposition:
- Shared package muldiv_pkg: function-code localparams, the state enum (IDLE/RUN/FIX), and the op-kind enum (MUL_S, MUL_U, DIV_S, DIV_U).
- One sub-module is natural: muldiv_iter_core. It holds the operand/accumulator registers and the single-step add/subtract-shift under an op-kind select.
- muldiv_sequencer keeps the FSM, counter, sign fix-up, HI/LO, and stall/mf logic.

Test Plan:
- multu A=7, B=6 -> exactly WIDTH+1 cycles busy; then hi=0x00000000, lo=0x0000002A; done pulses once.
- mult A=0xFFFFFFFD (-3), B=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Also multu 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- mfhi issued 3 cycles after mult accept -> stall=1 until done cycle; then mf_data=new hi and stall=0. An unrelated code (add 100000) during busy -> stall=0.
- mthi 0x12345678, then mflo after mtlo 0xCAFEBABE, both while idle -> hi=0x12345678, mf_data=0xCAFEBABE; no stall.
- reset_n pulled low mid-RUN (counter=10) -> hi/lo/busy/done=0 immediately; a new multu 2*3 after release -> lo=6.
- MULDIV_DIV_EN: div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 9/0 -> hi=9, lo=0xFFFFFFFF. Without the macro, div sets no stall and leaves hi/lo unchanged.
